cl_result_arbiter: RTL and testbench
====================================

# cl_result_arbiter

Merges the result streams of the NUM_CORES PairHMM compute cores into the single AXI-Stream result bus consumed by the write-back stage. It applies fair round-robin arbitration and buffers results in a small FIFO so that DDR4 write latency does not stall the cores. It also exposes a forwarded-result count for the main controller.

## Interface
Parameters:
- NUM_CORES, 4: number of core result inputs, range 1..16.
- FIFO_DEPTH, 8: result FIFO entries; must be a power of two and at least 2.

Ports (one clock; reset is synchronous and active-high):
- clock_i  in  1  system clock.
- reset_i  in  1  synchronous active-high reset.
- reset_arb_i  in  1  controller soft reset for a new batch; same effect as reset_i.
- core_result_valid_i  in  NUM_CORES  per-core result valid.
- core_result_data_i  in  NUM_CORES x PairHMMPackage::final_result_t  per-core result (id, result).
- core_result_ready_o  out  NUM_CORES  per-core accept; at most one bit set per cycle.
- axi_m_result_bus  axi_stream_generic_if.master  tdata = final_result_t, tvalid/tready; feeds the write-back stage.
- fifo_level_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy, 0..FIFO_DEPTH.
- results_forwarded_o  out  32  count of results handed over on axi_m_result_bus.

## Operation
- **State:** round-robin pointer rr_ptr (0..NUM_CORES-1), FIFO storage, read/write pointers, occupancy count, forwarded counter.
- **Arbitration:** performed every cycle in which count < FIFO_DEPTH. Candidates are scanned in order rr_ptr, rr_ptr+1, … (mod NUM_CORES). The first core with valid asserted is granted.
- **Ready:** core_result_ready_o[k] = grant[k], so ready depends combinationally on valid. Cores must not make valid depend on ready.
- **Pointer update:** on a grant to core k, rr_ptr ← (k+1) mod NUM_CORES. With no grant, rr_ptr holds.
- **Push:** a granted handshake writes core_result_data_i[k] to the FIFO at the write pointer. Data passes through unmodified.
- **Full FIFO:** when count == FIFO_DEPTH, no grant is made, even if a pop happens in the same cycle. Full means no accept, with no same-cycle refill.
- **Pop:** tvalid = (count != 0); tdata = FIFO head. A handshake (tvalid && tready) advances the read pointer.
- **Occupancy:** count +1 on push only, −1 on pop only, unchanged on simultaneous push and pop.
- **Pointer width:** pointers are $clog2(FIFO_DEPTH) bits and wrap naturally.
- **Forwarded counter:** results_forwarded_o increments by 1 on each output handshake and wraps 0xFFFFFFFF → 0.
- **Reset (reset_i or reset_arb_i), applied at the next edge:**
  - count, pointers, rr_ptr and results_forwarded_o all go to 0.
  - Buffered results are discarded.
  - FIFO storage contents need not be cleared.
  - An input handshake in the reset cycle is ignored.
- **Reset values of outputs:** core_result_ready_o = 0 while reset is asserted; tvalid = 0; fifo_level_o = 0; results_forwarded_o = 0.
- **Ordering:** results leave in FIFO order, with no reordering by id. The write-back stage addresses by id, so order is irrelevant to correctness.

## Timing
- Latency: a result accepted from a core at edge t appears on tvalid/tdata after edge t (next cycle), provided the FIFO was empty and not popped ahead of it.
- Throughput: one accept and one forward per cycle, sustained.
- Fairness: with all cores continuously valid, grants cycle 0,1,…,N-1,0,…. A waiting core is granted within NUM_CORES grants.
- tvalid, once asserted, holds with tdata stable until the handshake, because the head only changes on pop.
- fifo_level_o and results_forwarded_o are registered and reflect the edge that just occurred.
- Cores must not deassert a valid result before its handshake.

## Test plan
- **Single core:** core 2 presents id=5, result=0x3F800000, tready=1 → ready[2]=1 for one cycle; the next cycle has tvalid=1 with tdata id=5; results_forwarded_o=1; fifo_level_o returns to 0.
- **All cores simultaneous:** all 4 cores valid with ids 10..13, rr_ptr=0, tready=1 → grants on consecutive cycles to cores 0,1,2,3; output ids in order 10,11,12,13; rr_ptr=0 afterwards.
- **Backpressure:** tready=0 with core 0 streaming ids 0..11 → exactly 8 accepted, then fifo_level_o=8 and ready stays 0. Raising tready → ids 0..7 emerge in order, then acceptance resumes with id 8.
- **Full with simultaneous pop:** count=8, tready=1, a core valid → the pop happens, no grant that cycle, count=7. The grant occurs on the following cycle.
- **Soft reset mid-operation:** 5 entries buffered, results_forwarded_o=3, assert reset_arb_i for one cycle → tvalid=0, fifo_level_o=0, results_forwarded_o=0. A concurrent core handshake is dropped, and arbitration restarts at core 0.
- **Counter wrap:** preload the counter via force to 0xFFFFFFFF, forward one result → results_forwarded_o=0.

Source files
------------

// File: rtl/cl_result_arbiter_if.sv
// Generic AXI-Stream style link: a data word qualified by a valid/ready handshake.
interface axi_stream_generic_if #(
  parameter int DATA_W = 48
) ();
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;

  modport master (output tvalid, output tdata, input tready);
  modport slave  (input tvalid, input tdata, output tready);
endinterface

// File: rtl/cl_result_arbiter.sv
// Result arbiter: merges per-core PairHMM results into one stream through a
// round-robin arbiter and a small FIFO, and counts forwarded results.
package PairHMMPackage;
  typedef struct packed {
    logic [15:0] id;
    logic [31:0] result;
  } final_result_t;
endpackage

module cl_result_arbiter #(
  parameter int NUM_CORES  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                                           clock_i,
  input  logic                                           reset_i,
  input  logic                                           reset_arb_i,
  input  logic [NUM_CORES-1:0]                           core_result_valid_i,
  input  PairHMMPackage::final_result_t [NUM_CORES-1:0]  core_result_data_i,
  output logic [NUM_CORES-1:0]                           core_result_ready_o,
  axi_stream_generic_if.master                           axi_m_result_bus,
  output logic [$clog2(FIFO_DEPTH):0]                    fifo_level_o,
  output logic [31:0]                                    results_forwarded_o
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int RR_W  = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;

  logic                          soft_reset;
  logic [RR_W-1:0]               rr_ptr;
  logic [RR_W-1:0]               grant_idx;
  logic [NUM_CORES-1:0]          grant;
  logic                          grant_any;
  PairHMMPackage::final_result_t push_data;
  PairHMMPackage::final_result_t fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]              wr_ptr;
  logic [PTR_W-1:0]              rd_ptr;
  logic [CNT_W-1:0]              count;
  logic [31:0]                   forwarded_count;
  logic                          fifo_full;
  logic                          tvalid_int;
  logic                          push;
  logic                          pop;

  assign soft_reset = reset_i | reset_arb_i;
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign tvalid_int = (count != '0);
  assign pop        = tvalid_int & axi_m_result_bus.tready;
  assign push       = grant_any;

  // Round-robin pick: first scan cores at or above rr_ptr, then wrap to the
  // lowest-numbered valid core. A full FIFO or a pending reset blocks all grants,
  // even when a pop frees a slot in the same cycle.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    push_data = '0;
    if (!fifo_full && !soft_reset) begin
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!grant_any && core_result_valid_i[k] && (RR_W'(k) >= rr_ptr)) begin
          grant_any = 1'b1;
          grant_idx = RR_W'(k);
          grant[k]  = 1'b1;
          push_data = core_result_data_i[k];
        end
      end
      for (int k = 0; k < NUM_CORES; k++) begin
        if (!grant_any && core_result_valid_i[k]) begin
          grant_any = 1'b1;
          grant_idx = RR_W'(k);
          grant[k]  = 1'b1;
          push_data = core_result_data_i[k];
        end
      end
    end
  end

  assign core_result_ready_o     = grant;
  assign axi_m_result_bus.tvalid = tvalid_int;
  assign axi_m_result_bus.tdata  = fifo_mem[rd_ptr];
  assign fifo_level_o            = count;
  assign results_forwarded_o     = forwarded_count;

  // FIFO storage is left uncleared on reset; the pointers alone define what is live.
  always_ff @(posedge clock_i) begin
    if (push) begin
      fifo_mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy, round-robin position and forwarded counter.
  always_ff @(posedge clock_i) begin
    if (soft_reset) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      rr_ptr          <= '0;
      forwarded_count <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
        rr_ptr <= (grant_idx == RR_W'(NUM_CORES - 1)) ? '0 : grant_idx + 1'b1;
      end
      if (pop) begin
        rd_ptr          <= rd_ptr + 1'b1;
        forwarded_count <= forwarded_count + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_cl_result_arbiter.sv
// Self-checking bench for cl_result_arbiter with four cores and an 8-entry FIFO.
module tb_cl_result_arbiter;
  import PairHMMPackage::*;

  logic                    clock_i;
  logic                    reset_i;
  logic                    reset_arb_i;
  logic [3:0]              core_result_valid_i;
  final_result_t [3:0]     core_result_data_i;
  logic [3:0]              core_result_ready_o;
  logic [3:0]              fifo_level_o;
  logic [31:0]             results_forwarded_o;

  axi_stream_generic_if #(.DATA_W($bits(final_result_t))) result_bus ();

  cl_result_arbiter #(.NUM_CORES(4), .FIFO_DEPTH(8)) dut (
    .clock_i             (clock_i),
    .reset_i             (reset_i),
    .reset_arb_i         (reset_arb_i),
    .core_result_valid_i (core_result_valid_i),
    .core_result_data_i  (core_result_data_i),
    .core_result_ready_o (core_result_ready_o),
    .axi_m_result_bus    (result_bus),
    .fifo_level_o        (fifo_level_o),
    .results_forwarded_o (results_forwarded_o)
  );

  typedef struct {
    logic             rst;
    logic             rst_arb;
    logic             tready;
    logic [3:0]       valid;
    logic [3:0][15:0] ids;
    logic [3:0][31:0] res;
    logic [3:0]       exp_ready;
    logic             exp_tvalid;
    logic [15:0]      exp_id;
    logic [31:0]      exp_res;
    logic [3:0]       exp_level;
    logic [31:0]      exp_fwd;
  } vec_t;

  vec_t vecs [16];
  int   num_checks = 0;
  int   num_fails  = 0;
  int   next_id;
  int   out_idx;

  initial clock_i = 1'b0;
  always #5 clock_i = ~clock_i;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic vec_t mkv(input logic rst, input logic rst_arb, input logic tready,
                               input logic [3:0] valid, input logic [3:0][15:0] ids,
                               input logic [3:0] exp_ready, input logic exp_tvalid,
                               input logic [15:0] exp_id, input logic [3:0] exp_level,
                               input logic [31:0] exp_fwd);
    vec_t v;
    v.rst        = rst;
    v.rst_arb    = rst_arb;
    v.tready     = tready;
    v.valid      = valid;
    v.ids        = ids;
    for (int c = 0; c < 4; c++) v.res[c] = {16'hC0DE, ids[c]};
    v.exp_ready  = exp_ready;
    v.exp_tvalid = exp_tvalid;
    v.exp_id     = exp_id;
    v.exp_res    = {16'hC0DE, exp_id};
    v.exp_level  = exp_level;
    v.exp_fwd    = exp_fwd;
    return v;
  endfunction

  task automatic applyStimulus(input vec_t v);
    reset_i             = v.rst;
    reset_arb_i         = v.rst_arb;
    result_bus.tready   = v.tready;
    core_result_valid_i = v.valid;
    for (int c = 0; c < 4; c++) core_result_data_i[c] = {v.ids[c], v.res[c]};
  endtask

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    num_checks++;
    if (actual !== expected) begin
      num_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic driveCore(input int core, input int id);
    core_result_data_i[core] = {16'(id), 16'hC0DE, 16'(id)};
  endtask

  initial begin
    // vectors: rst, rst_arb, tready, valid, ids{c3,c2,c1,c0}, exp ready, tvalid, id, level, fwd
    vecs[0]  = mkv(1, 0, 1, 4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 4'b0000, 0, 16'd0, 4'd0, 32'd0);
    vecs[1]  = mkv(0, 0, 1, 4'b0100, {16'd0, 16'd5, 16'd0, 16'd0}, 4'b0100, 0, 16'd0, 4'd0, 32'd0);
    vecs[2]  = mkv(0, 0, 1, 4'b0000, 64'd0, 4'b0000, 1, 16'd5, 4'd1, 32'd0);
    vecs[3]  = mkv(0, 0, 1, 4'b0000, 64'd0, 4'b0000, 0, 16'd0, 4'd0, 32'd1);
    vecs[4]  = mkv(0, 1, 1, 4'b0000, 64'd0, 4'b0000, 0, 16'd0, 4'd0, 32'd1);
    vecs[5]  = mkv(0, 0, 1, 4'b1111, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b0001, 0, 16'd0, 4'd0, 32'd0);
    vecs[6]  = mkv(0, 0, 1, 4'b1110, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b0010, 1, 16'd10, 4'd1, 32'd0);
    vecs[7]  = mkv(0, 0, 1, 4'b1100, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b0100, 1, 16'd11, 4'd1, 32'd1);
    vecs[8]  = mkv(0, 0, 1, 4'b1000, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b1000, 1, 16'd12, 4'd1, 32'd2);
    vecs[9]  = mkv(0, 0, 1, 4'b0000, {16'd13, 16'd12, 16'd11, 16'd10}, 4'b0000, 1, 16'd13, 4'd1, 32'd3);
    vecs[10] = mkv(0, 0, 1, 4'b1001, {16'd23, 16'd0, 16'd0, 16'd20}, 4'b0001, 0, 16'd0, 4'd0, 32'd4);
    vecs[11] = mkv(0, 0, 0, 4'b1000, {16'd23, 16'd0, 16'd0, 16'd20}, 4'b1000, 1, 16'd20, 4'd1, 32'd4);
    vecs[12] = mkv(0, 0, 0, 4'b0000, 64'd0, 4'b0000, 1, 16'd20, 4'd2, 32'd4);
    vecs[13] = mkv(0, 0, 1, 4'b0000, 64'd0, 4'b0000, 1, 16'd20, 4'd2, 32'd4);
    vecs[14] = mkv(0, 0, 1, 4'b0000, 64'd0, 4'b0000, 1, 16'd23, 4'd1, 32'd5);
    vecs[15] = mkv(0, 0, 1, 4'b0000, 64'd0, 4'b0000, 0, 16'd0, 4'd0, 32'd6);
    vecs[0].res[2]  = 32'h3F800000;
    vecs[1].res[2]  = 32'h3F800000;
    vecs[2].exp_res = 32'h3F800000;

    reset_i             = 1'b1;
    reset_arb_i         = 1'b0;
    result_bus.tready   = 1'b0;
    core_result_valid_i = '0;
    core_result_data_i  = '0;
    repeat (2) @(posedge clock_i);

    for (int i = 0; i < 16; i++) begin
      @(negedge clock_i);
      applyStimulus(vecs[i]);
      #1;
      checkOutput($sformatf("vec%0d ready", i), core_result_ready_o, vecs[i].exp_ready);
      checkOutput($sformatf("vec%0d tvalid", i), result_bus.tvalid, vecs[i].exp_tvalid);
      checkOutput($sformatf("vec%0d level", i), fifo_level_o, vecs[i].exp_level);
      checkOutput($sformatf("vec%0d forwarded", i), results_forwarded_o, vecs[i].exp_fwd);
      if (vecs[i].exp_tvalid)
        checkOutput($sformatf("vec%0d tdata", i), result_bus.tdata, {vecs[i].exp_id, vecs[i].exp_res});
    end

    // Backpressure: core 0 streams ids 0..11 into a stalled output.
    @(negedge clock_i);
    reset_i = 1'b0; reset_arb_i = 1'b1; core_result_valid_i = '0; result_bus.tready = 1'b0;
    next_id = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock_i);
      reset_arb_i = 1'b0;
      core_result_valid_i = 4'b0001;
      driveCore(0, next_id);
      #1;
      checkOutput($sformatf("bp accept cycle %0d", c), core_result_ready_o, (c < 8) ? 4'b0001 : 4'b0000);
      if (core_result_ready_o[0]) next_id++;
    end

    // Full FIFO with a simultaneous pop: pop happens, no grant this cycle.
    @(negedge clock_i);
    driveCore(0, next_id);
    result_bus.tready = 1'b1;
    #1;
    checkOutput("full level", fifo_level_o, 4'd8);
    checkOutput("full no grant", core_result_ready_o, 4'b0000);
    checkOutput("full head id", result_bus.tdata[47:32], 16'd0);
    out_idx = 1;
    @(negedge clock_i);
    #1;
    checkOutput("after pop level", fifo_level_o, 4'd7);
    checkOutput("grant after full", core_result_ready_o, 4'b0001);
    checkOutput("second head id", result_bus.tdata[47:32], 16'd1);
    out_idx = 2;
    if (core_result_ready_o[0]) next_id++;
    for (int c = 0; c < 40 && out_idx < 12; c++) begin
      @(negedge clock_i);
      core_result_valid_i = (next_id < 12) ? 4'b0001 : 4'b0000;
      driveCore(0, next_id);
      #1;
      if (result_bus.tvalid) begin
        checkOutput($sformatf("bp order %0d", out_idx), result_bus.tdata, {16'(out_idx), 16'hC0DE, 16'(out_idx)});
        out_idx++;
      end
      if (core_result_ready_o[0]) next_id++;
    end
    checkOutput("bp drained count", out_idx, 12);
    checkOutput("bp accepted count", next_id, 12);
    @(negedge clock_i);
    core_result_valid_i = '0;
    #1;
    checkOutput("bp empty level", fifo_level_o, 4'd0);

    // Soft reset mid-operation: 5 buffered, 3 forwarded, then reset_arb_i.
    @(negedge clock_i);
    reset_arb_i = 1'b1; result_bus.tready = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock_i);
      reset_arb_i = 1'b0;
      core_result_valid_i = 4'b0010;
      driveCore(1, 40 + c);
      #1;
      checkOutput($sformatf("sr fill %0d", c), core_result_ready_o, 4'b0010);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock_i);
      core_result_valid_i = '0;
      result_bus.tready = 1'b1;
      #1;
      checkOutput($sformatf("sr pop %0d", c), result_bus.tdata[47:32], 16'(40 + c));
    end
    @(negedge clock_i);
    reset_arb_i = 1'b1;
    core_result_valid_i = 4'b1000;
    driveCore(3, 99);
    #1;
    checkOutput("sr level before", fifo_level_o, 4'd5);
    checkOutput("sr forwarded before", results_forwarded_o, 32'd3);
    checkOutput("sr ready during reset", core_result_ready_o, 4'b0000);
    @(negedge clock_i);
    reset_arb_i = 1'b0;
    result_bus.tready = 1'b0;
    core_result_valid_i = 4'b1001;
    driveCore(0, 77);
    #1;
    checkOutput("sr tvalid after", result_bus.tvalid, 1'b0);
    checkOutput("sr level after", fifo_level_o, 4'd0);
    checkOutput("sr forwarded after", results_forwarded_o, 32'd0);
    checkOutput("sr restart core0", core_result_ready_o, 4'b0001);
    @(negedge clock_i);
    core_result_valid_i = '0;
    #1;
    checkOutput("sr level one", fifo_level_o, 4'd1);
    checkOutput("sr head id", result_bus.tdata[47:32], 16'd77);

    // Forwarded counter wrap.
    force dut.forwarded_count = 32'hFFFF_FFFF;
    @(negedge clock_i);
    release dut.forwarded_count;
    result_bus.tready = 1'b1;
    @(negedge clock_i);
    result_bus.tready = 1'b0;
    #1;
    checkOutput("counter wrap", results_forwarded_o, 32'd0);
    checkOutput("wrap level", fifo_level_o, 4'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
